// File: rtl/mil_spi_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
package mil_spi_pkg;

  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } sram_state_t;

endpackage

// File: rtl/ip_sram_ctrl.sv
// Asynchronous SRAM controller: single-word read/write with a fixed
// SETUP / ACCESS(WAIT_CYCLES) / HOLD strobe sequence.
// Optional build macro SRAM_CTRL_RDSYNC_EN adds an input register on
// sram_dq_in and a CAPTURE state on reads (one extra cycle of read latency).
module ip_sram_ctrl
  import mil_spi_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  input  logic                   req_rd,
  input  logic                   req_wr,
  output logic                   busy,
  output logic                   done,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   err,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  sram_state_t state;
  logic        op_wr;
  logic [3:0]  cnt;

`ifdef SRAM_CTRL_RDSYNC_EN
  logic [SRAM_DATA_W-1:0] dq_in_q;

  // Input register for the SRAM read bus.
  always_ff @(posedge clk) begin
    if (rst) dq_in_q <= '0;
    else     dq_in_q <= sram_dq_in;
  end
`endif

  assign busy = (state != S_IDLE);

  // Access sequencer; every SRAM strobe is registered on the edge that
  // enters the state it belongs to, so the pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_wr       <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_rd || req_wr) begin
            // write wins when both are requested; the read is dropped
            state       <= S_SETUP;
            op_wr       <= req_wr;
            err         <= req_rd && req_wr;
            sram_addr   <= req_addr;
            sram_dq_out <= req_wdata;
            sram_ce_n   <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= req_wr;
            sram_dq_oe  <= req_wr;
          end
        end
        S_SETUP: begin
          state     <= S_ACCESS;
          cnt       <= CNT_LOAD;
          sram_we_n <= ~op_wr;
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            sram_we_n <= 1'b1;
            if (op_wr) begin
              state <= S_HOLD;
              done  <= 1'b1;
            end else begin
`ifdef SRAM_CTRL_RDSYNC_EN
              state <= S_CAPTURE;
`else
              rdata <= sram_dq_in;
              state <= S_HOLD;
              done  <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef SRAM_CTRL_RDSYNC_EN
        S_CAPTURE: begin
          rdata <= dq_in_q;
          state <= S_HOLD;
          done  <= 1'b1;
        end
`endif
        S_HOLD: begin
          state      <= S_IDLE;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_sram_ctrl.sv
// Directed self-checking bench for ip_sram_ctrl (instances with
// WAIT_CYCLES = 2, 1 and 15).
module tb_ip_sram_ctrl;

`ifdef SRAM_CTRL_RDSYNC_EN
  localparam int RDX = 1;
`else
  localparam int RDX = 0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [2:0]  rd_v;
  logic [2:0]  wr_v;
  logic [2:0]  busy_v, done_v, err_v, dq_oe_v, ce_n_v, oe_n_v, we_n_v;
  logic [15:0] rdata_v   [3];
  logic [15:0] addr_o_v  [3];
  logic [15:0] dq_out_v  [3];
  logic [15:0] dq_in_v   [3];
  logic [15:0] mem [0:255];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  int t_lat, t_we, t_oe, t_dqoe, t_err, t_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ip_sram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_addr(addr), .req_wdata(wdata),
    .req_rd(rd_v[0]), .req_wr(wr_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rdata(rdata_v[0]), .err(err_v[0]), .sram_addr(addr_o_v[0]),
    .sram_dq_out(dq_out_v[0]), .sram_dq_oe(dq_oe_v[0]), .sram_dq_in(dq_in_v[0]),
    .sram_ce_n(ce_n_v[0]), .sram_oe_n(oe_n_v[0]), .sram_we_n(we_n_v[0]));

  ip_sram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_addr(addr), .req_wdata(wdata),
    .req_rd(rd_v[1]), .req_wr(wr_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rdata(rdata_v[1]), .err(err_v[1]), .sram_addr(addr_o_v[1]),
    .sram_dq_out(dq_out_v[1]), .sram_dq_oe(dq_oe_v[1]), .sram_dq_in(dq_in_v[1]),
    .sram_ce_n(ce_n_v[1]), .sram_oe_n(oe_n_v[1]), .sram_we_n(we_n_v[1]));

  ip_sram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .req_addr(addr), .req_wdata(wdata),
    .req_rd(rd_v[2]), .req_wr(wr_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .rdata(rdata_v[2]), .err(err_v[2]), .sram_addr(addr_o_v[2]),
    .sram_dq_out(dq_out_v[2]), .sram_dq_oe(dq_oe_v[2]), .sram_dq_in(dq_in_v[2]),
    .sram_ce_n(ce_n_v[2]), .sram_oe_n(oe_n_v[2]), .sram_we_n(we_n_v[2]));

  // SRAM models: instance 0 backed by memory, sweep instances return a constant
  assign dq_in_v[0] = (!ce_n_v[0] && !oe_n_v[0]) ? mem[addr_o_v[0][7:0]] : 16'hDEAD;
  assign dq_in_v[1] = (!ce_n_v[1] && !oe_n_v[1]) ? 16'h5A5A : 16'hDEAD;
  assign dq_in_v[2] = (!ce_n_v[2] && !oe_n_v[2]) ? 16'h5A5A : 16'hDEAD;

  // Memory write model for instance 0, preloaded while in reset
  always @(posedge clk) begin
    if (rst) mem[8'h10] <= 16'hA5C3;
    else if (!ce_n_v[0] && !we_n_v[0] && dq_oe_v[0])
      mem[addr_o_v[0][7:0]] <= dq_out_v[0];
  end

  // Bus protocol monitor: no we/oe overlap, never drive while SRAM drives
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        total++;
        assert (!(!we_n_v[k] && !oe_n_v[k]) && !(dq_oe_v[k] && !oe_n_v[k])) else begin
          bad++;
          $error("FAIL protocol inst%0d: we_n=%b oe_n=%b dq_oe=%b required no overlap",
                 k, we_n_v[k], oe_n_v[k], dq_oe_v[k]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance k and observe ncyc cycles after acceptance.
  // Cycle 1 is the first cycle after the accept edge; t_lat is the cycle in
  // which done is first seen. A read pulse is injected in cycle pulse_at.
  task automatic txn(input int k, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     input int pulse_at, input int ncyc, input bit nowait);
    if (!nowait) begin
      @(posedge clk); #1;
    end
    addr = a; wdata = d; rd_v[k] = rd; wr_v[k] = wr;
    @(posedge clk); #1;
    rd_v[k] = 1'b0; wr_v[k] = 1'b0;
    t_lat = 0; t_we = 0; t_oe = 0; t_dqoe = 0; t_err = 0; t_done = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (!we_n_v[k]) t_we++;
      if (!oe_n_v[k]) t_oe++;
      if (dq_oe_v[k]) t_dqoe++;
      if (err_v[k])   t_err++;
      if (done_v[k]) begin
        t_done++;
        if (t_lat == 0) t_lat = i;
      end
      rd_v[k] = (i == pulse_at);
      @(posedge clk); #1;
    end
    rd_v[k] = 1'b0;
  endtask

  initial begin
    int dseen;
    rst = 1'b1; addr = '0; wdata = '0; rd_v = '0; wr_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {29'd0, busy_v}, 32'h0);
    check("rst_done",   done_v[0], 1'b0);
    check("rst_err",    err_v[0], 1'b0);
    check("rst_rdata",  rdata_v[0], 16'h0);
    check("rst_addr",   addr_o_v[0], 16'h0);
    check("rst_dqout",  dq_out_v[0], 16'h0);
    check("rst_dqoe",   dq_oe_v[0], 1'b0);
    check("rst_strobe", {ce_n_v[0], oe_n_v[0], we_n_v[0]}, 3'b111);
    rst = 1'b0;
    mon_en = 1'b1;

    // write 0xBEEF to 0x1234
    txn(0, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 0, 8, 1'b0);
    check("wr_lat",    t_lat, 4);
    check("wr_we_len", t_we, 2);
    check("wr_dqoe",   t_dqoe, 4);
    check("wr_oe",     t_oe, 0);
    check("wr_done",   t_done, 1);
    check("wr_err",    t_err, 0);
    check("wr_mem",    mem[8'h34], 16'hBEEF);
    check("idle_addr", addr_o_v[0], 16'h1234);
    check("idle_ce",   ce_n_v[0], 1'b1);

    // read 0xA5C3 from 0x0010
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 9, 1'b0);
    check("rd_lat",   t_lat, 4 + RDX);
    check("rd_data",  rdata_v[0], 16'hA5C3);
    check("rd_oe",    t_oe, 4 + RDX);
    check("rd_dqoe",  t_dqoe, 0);
    check("rd_we",    t_we, 0);
    check("rd_done",  t_done, 1);

    // simultaneous read and write: write only, err pulse
    txn(0, 1'b1, 1'b1, 16'h0001, 16'h0F0F, 0, 8, 1'b0);
    check("both_err",   t_err, 1);
    check("both_mem",   mem[8'h01], 16'h0F0F);
    check("both_oe",    t_oe, 0);
    check("both_we",    t_we, 2);
    check("both_rdata", rdata_v[0], 16'hA5C3);
    check("both_done",  t_done, 1);

    // request pulsed while busy is ignored
    txn(0, 1'b0, 1'b1, 16'h0020, 16'h1111, 2, 12, 1'b0);
    check("busy_done", t_done, 1);
    check("busy_mem",  mem[8'h20], 16'h1111);
    check("busy_idle", busy_v[0], 1'b0);

    // back-to-back: request in the cycle right after done
    txn(0, 1'b0, 1'b1, 16'h0030, 16'h2222, 0, 4, 1'b0);
    check("b2b_first_lat", t_lat, 4);
    check("b2b_idle",      busy_v[0], 1'b0);
    txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 0, 9, 1'b1);
    check("b2b_lat",   t_lat, 4 + RDX);
    check("b2b_done",  t_done, 1);
    check("b2b_rdata", rdata_v[0], 16'h2222);

    // reset during ACCESS of a write
    @(posedge clk); #1;
    addr = 16'h0040; wdata = 16'h3333; wr_v[0] = 1'b1;
    @(posedge clk); #1;
    wr_v[0] = 1'b0;
    @(posedge clk); #1;
    check("mid_in_access", we_n_v[0], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_we",    we_n_v[0], 1'b1);
    check("mid_ce",    ce_n_v[0], 1'b1);
    check("mid_dqoe",  dq_oe_v[0], 1'b0);
    check("mid_busy",  busy_v[0], 1'b0);
    check("mid_rdata", rdata_v[0], 16'h0);
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_v[0]) dseen++;
      @(posedge clk); #1;
    end
    check("mid_no_done", dseen, 0);

    // WAIT_CYCLES sweep
    txn(1, 1'b0, 1'b1, 16'h0100, 16'h7777, 0, 6, 1'b0);
    check("w1_we_len", t_we, 1);
    check("w1_lat",    t_lat, 3);
    check("w1_dqoe",   t_dqoe, 3);
    txn(1, 1'b1, 1'b0, 16'h0101, 16'h0000, 0, 7, 1'b0);
    check("w1_rd_lat", t_lat, 3 + RDX);
    check("w1_rdata",  rdata_v[1], 16'h5A5A);
    txn(2, 1'b0, 1'b1, 16'h0200, 16'h8888, 0, 20, 1'b0);
    check("w15_we_len", t_we, 15);
    check("w15_lat",    t_lat, 17);
    check("w15_dqoe",   t_dqoe, 17);
    txn(2, 1'b1, 1'b0, 16'h0201, 16'h0000, 0, 21, 1'b0);
    check("w15_rd_lat", t_lat, 17 + RDX);
    check("w15_oe",     t_oe, 17 + RDX);
    check("w15_rdata",  rdata_v[2], 16'h5A5A);

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
